// File: rtl/matrix_stream_loader.sv
// ----------------------------------------------------------------------------
// matrix_stream_loader
//   Collects DIM*DIM signed elements, one per valid/ready beat, in row-major
//   order terminated by a last marker. Packs them into one flat matrix bus for
//   the determinant unit and holds that matrix under a valid/ready handshake
//   until the consumer takes it. Malformed frames are discarded and flagged
//   with a one-cycle frame_err pulse.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous reset, active low
//   clear      in   1       synchronous abort of partial/held matrix
//   in_data    in   ELEM_W  element value, stored bit-exact
//   in_valid   in   1       in_data/in_last valid
//   in_last    in   1       final element of a frame
//   in_ready   out  1       element accepted this cycle when in_valid
//   out_matrix out  MAT_W   element k at [MAT_W-1-k*ELEM_W -: ELEM_W]
//   out_valid  out  1       out_matrix complete and stable
//   out_ready  in   1       consumer takes out_matrix this cycle
//   frame_err  out  1       one-cycle pulse, malformed frame discarded
//   elem_cnt   out  4       elements accepted in the current frame
// ----------------------------------------------------------------------------
module matrix_stream_loader #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 3,
    parameter int MAT_W  = DIM*DIM*ELEM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [MAT_W-1:0]  out_matrix,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic [3:0]        elem_cnt
);

    localparam int         N        = DIM*DIM;
    localparam logic [3:0] LAST_IDX = 4'(N-1);

    // S_DROP is the resync sub-mode of loading after an over-long frame:
    // the stream is still accepted but discarded up to the next in_last.
    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_DROP = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [3:0]                    r_cnt;
    logic [3:0]                    w_cnt_nxt;
    logic [N-1:0][ELEM_W-1:0]      r_mat;
    logic [N-1:0][ELEM_W-1:0]      w_mat_nxt;
    logic                          r_err;
    logic                          w_err_nxt;
    logic                          w_in_beat;
    logic                          w_out_beat;
    logic                          w_store;
    logic                          w_zero;

    // Handshake outputs are pure state decode: nothing combinational from
    // in_valid reaches the output side.
    assign in_ready   = (r_state != S_FULL);
    assign out_valid  = (r_state == S_FULL);
    assign out_matrix = r_mat;
    assign frame_err  = r_err;
    assign elem_cnt   = r_cnt;

    assign w_in_beat  = in_valid && in_ready;
    assign w_out_beat = out_valid && out_ready;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_mat   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mat   <= w_mat_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        w_store     = 1'b0;
        w_zero      = 1'b0;

        if (clear) begin
            w_state_nxt = S_LOAD;
            w_cnt_nxt   = '0;
            w_zero      = 1'b1;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    if (w_in_beat) begin
                        if (r_cnt == LAST_IDX) begin
                            w_cnt_nxt = '0;
                            if (in_last) begin
                                w_store     = 1'b1;
                                w_state_nxt = S_FULL;
                            end else begin
                                // Too long: flag once, then swallow the rest
                                w_zero      = 1'b1;
                                w_err_nxt   = 1'b1;
                                w_state_nxt = S_DROP;
                            end
                        end else if (in_last) begin
                            // Too short
                            w_cnt_nxt = '0;
                            w_zero    = 1'b1;
                            w_err_nxt = 1'b1;
                        end else begin
                            w_store   = 1'b1;
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end
                end
                S_DROP: begin
                    if (w_in_beat && in_last) begin
                        w_state_nxt = S_LOAD;
                    end
                end
                S_FULL: begin
                    if (w_out_beat) begin
                        w_state_nxt = S_LOAD;
                        w_zero      = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = '0;
                    w_zero      = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Matrix slots. Element k lives in r_mat[N-1-k] so element 0 lands in
    // the MSBs of the flat bus.
    // ------------------------------------------------------------------------
    always_comb begin
        w_mat_nxt = r_mat;
        if (w_zero) begin
            w_mat_nxt = '0;
        end else if (w_store) begin
            for (int k = 0; k < N; k++) begin
                if (r_cnt == 4'(k)) begin
                    w_mat_nxt[N-1-k] = in_data;
                end
            end
        end
    end

endmodule
